scanner_sequencer: RTL and testbench

Host-side initiator for the dual-scanner subsystem. Watches both scanners' state buses, generates each scanner's 4-bit buffer progress count, and issues the one-cycle command pulses (standby, scan, transfer, flush) that drive the scanner state machines. It implements ping-pong operation: one scanner scans while the other is brought up, and filled buffers are drained over a single shared transfer channel.

---
 rtl/scanner_pkg.sv | 31 +++
 rtl/scan_prog_counter.sv | 31 +++
 rtl/scanner_sequencer.sv | 127 ++++++++++++
 tb/tb_scanner_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared encodings for the dual-scanner subsystem: scanner state bus values,
// buffer fill limits and the sequencer's command bundle.
package scanner_pkg;

  localparam int NUM_SCAN = 2;

  typedef enum logic [2:0] {
    ST_LOWPOWER = 3'b000,
    ST_STANDBY  = 3'b001,
    ST_SCANNING = 3'b010,
    ST_IDLE     = 3'b011,
    ST_XFERRING = 3'b100,
    ST_FLUSHING = 3'b101
  } scan_state_e;

  typedef enum logic {
    SEQ_OFF = 1'b0,
    SEQ_RUN = 1'b1
  } seq_state_e;

  localparam logic [3:0] PROG_FULL  = 4'd10;
  localparam logic [3:0] PROG_EMPTY = 4'd0;

  typedef struct packed {
    logic [NUM_SCAN-1:0] stby;
    logic [NUM_SCAN-1:0] scan;
    logic [NUM_SCAN-1:0] xfer;
    logic [NUM_SCAN-1:0] flush;
  } cmd_t;

endpackage

// File: rtl/scan_prog_counter.sv
// Per-scanner buffer fill counter: follows the scanner state on each divider
// tick, saturating at PROG_EMPTY and PROG_FULL.
module scan_prog_counter
  import scanner_pkg::*;
#(
  parameter int FLUSH_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       tick,
  output logic [3:0] prog
);

  localparam logic [3:0] STEP = 4'(FLUSH_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      prog <= PROG_EMPTY;
    end else if (tick) begin
      case (scan_state_e'(state))
        ST_SCANNING: if (prog < PROG_FULL)  prog <= prog + 4'd1;
        ST_XFERRING: if (prog > PROG_EMPTY) prog <= prog - 4'd1;
        // A flush drains FLUSH_STEP per tick but never below empty.
        ST_FLUSHING: prog <= (prog > STEP) ? prog - STEP : PROG_EMPTY;
        default:     prog <= prog;
      endcase
    end
  end

endmodule

// File: rtl/scanner_sequencer.sv
// Host-side ping-pong sequencer for two scanners: tracks buffer fill, hands
// the active role between scanners and arbitrates the shared transfer channel.
module scanner_sequencer
  import scanner_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int STANDBY_AT = 5,
  parameter int FLUSH_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       xfer_ready,
  input  logic [2:0] state0,
  input  logic [2:0] state1,
  output logic [1:0] go_to_standby,
  output logic [1:0] start_scan,
  output logic [1:0] start_transfer,
  output logic [1:0] flush,
  output logic [3:0] prog0,
  output logic [3:0] prog1,
  output logic       active_scanner,
  output logic       running
);

  localparam int         DW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] STBY_AT = 4'(STANDBY_AT);

  seq_state_e seq_q, seq_d;
  logic [DW-1:0] div_cnt;
  logic          tick;

  logic [NUM_SCAN-1:0][2:0] st, prev_st;
  logic [NUM_SCAN-1:0][3:0] prog_w, prev_prog;
  logic [NUM_SCAN-1:0]      is_idle, idle_entry, xq;
  logic                     any_xfer;

  cmd_t cmd_q, cmd_d;
  logic active_q, active_d;
  logic first_idle, first_idle_d;
  logic c, o;

  assign st   = {state1, state0};
  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  for (genvar gi = 0; gi < NUM_SCAN; gi++) begin : g_scan
    scan_prog_counter #(.FLUSH_STEP(FLUSH_STEP)) u_prog (
      .clk   (clk),
      .reset (reset),
      .state (st[gi]),
      .tick  (tick),
      .prog  (prog_w[gi])
    );
    assign is_idle[gi]    = (st[gi] == ST_IDLE);
    assign idle_entry[gi] = is_idle[gi] && (prev_st[gi] != ST_IDLE);
  end

  assign any_xfer = (st[0] == ST_XFERRING) || (st[1] == ST_XFERRING);
  assign c        = active_q;
  assign o        = ~active_q;

  always_comb begin
    seq_d = seq_q;
    if (seq_q == SEQ_OFF && start) seq_d = SEQ_RUN;
  end

  // Oldest idle buffer: set on a lone idle entry, handed over when it leaves.
  always_comb begin
    first_idle_d = first_idle;
    if (idle_entry[0] && !is_idle[1])
      first_idle_d = 1'b0;
    else if (idle_entry[1] && !is_idle[0])
      first_idle_d = 1'b1;
    else if (!is_idle[first_idle] && is_idle[~first_idle])
      first_idle_d = ~first_idle;
  end

  always_comb begin
    cmd_d    = '0;
    active_d = active_q;
    for (int i = 0; i < NUM_SCAN; i++)
      xq[i] = is_idle[i] && xfer_ready && !any_xfer && !cmd_q.xfer[i];
    if (seq_q == SEQ_RUN) begin
      if (prog_w[c] == STBY_AT && prev_prog[c] != STBY_AT && st[o] == ST_LOWPOWER)
        cmd_d.stby[o] = 1'b1;
      if (idle_entry[c]) begin
        if (st[o] == ST_STANDBY) cmd_d.scan[o] = 1'b1;
        active_d = o;
      end
      if (xq == 2'b11) cmd_d.xfer[first_idle] = 1'b1;
      else             cmd_d.xfer             = xq;
      // Both buffers full and nothing draining: discard the oldest.
      if (is_idle == 2'b11 && cmd_d.xfer == '0 && !cmd_q.flush[first_idle])
        cmd_d.flush[first_idle] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= SEQ_OFF;
      div_cnt    <= '0;
      cmd_q      <= '0;
      active_q   <= 1'b0;
      first_idle <= 1'b0;
      prev_st    <= '0;
      prev_prog  <= '0;
    end else begin
      seq_q      <= seq_d;
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      cmd_q      <= cmd_d;
      active_q   <= active_d;
      first_idle <= first_idle_d;
      prev_st    <= st;
      prev_prog  <= prog_w;
    end
  end

  assign go_to_standby  = cmd_q.stby;
  assign start_scan     = cmd_q.scan;
  assign start_transfer = cmd_q.xfer;
  assign flush          = cmd_q.flush;
  assign prog0          = prog_w[0];
  assign prog1          = prog_w[1];
  assign active_scanner = active_q;
  assign running        = (seq_q == SEQ_RUN);

endmodule

// File: tb/tb_scanner_sequencer.sv
// Bench for scanner_sequencer: timed vector rows feed a scoreboard queue that
// a monitor drains one edge at a time, plus a per-cycle one-hot command check.
module tb_scanner_sequencer;
  import scanner_pkg::*;

  localparam logic [2:0] LP = 3'd0, SB = 3'd1, SC = 3'd2, ID = 3'd3, XF = 3'd4, FL = 3'd5;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, xfer_ready = 1'b0;
  logic [2:0] state0 = LP, state1 = LP;
  logic [1:0] go_to_standby, start_scan, start_transfer, flush;
  logic [3:0] prog0, prog1;
  logic       active_scanner, running;

  always #5 clk = ~clk;

  scanner_sequencer #(.TICK_DIV(4), .STANDBY_AT(5), .FLUSH_STEP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .xfer_ready(xfer_ready),
    .state0(state0), .state1(state1),
    .go_to_standby(go_to_standby), .start_scan(start_scan),
    .start_transfer(start_transfer), .flush(flush),
    .prog0(prog0), .prog1(prog1),
    .active_scanner(active_scanner), .running(running)
  );

  typedef struct {
    int          n;
    logic        rst, st, xr;
    logic [2:0]  s0, s1;
    logic [17:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          n;
    logic [17:0] exp;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   cyc = -2;
  int   errors = 0, checks = 0;

  function automatic vec_t mk(int n, logic rst, logic st, logic [2:0] s0, logic [2:0] s1,
                              logic xr, logic [1:0] g, logic [1:0] s, logic [1:0] x,
                              logic [1:0] f, logic [3:0] p0, logic [3:0] p1,
                              logic a, logic r, string name);
    vec_t v;
    v.n = n; v.rst = rst; v.st = st; v.s0 = s0; v.s1 = s1; v.xr = xr;
    v.exp = {g, s, x, f, p0, p1, a, r};
    v.name = name;
    return v;
  endfunction

  // Expectation for edge v.n goes on the scoreboard, then v's inputs are
  // driven just after that edge.
  task automatic apply(input vec_t v);
    sbq.push_back('{v.n, v.exp, v.name});
    wait (cyc >= v.n);
    reset = v.rst; start = v.st; state0 = v.s0; state1 = v.s1; xfer_ready = v.xr;
  endtask

  // Monitor: 1 time unit after every rising edge
  initial begin
    sb_t         e;
    logic [17:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= 0) begin
        checks++;
        if ($countones(go_to_standby) > 1 || $countones(start_scan) > 1 ||
            $countones(start_transfer) > 1 || $countones(flush) > 1) begin
          errors++;
          $display("FAIL onehot cyc=%0d got gts=%b scan=%b xfer=%b flush=%b",
                   cyc, go_to_standby, start_scan, start_transfer, flush);
        end
      end
      got = {go_to_standby, start_scan, start_transfer, flush, prog0, prog1,
             active_scanner, running};
      while (sbq.size() > 0 && sbq[0].n <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (e.n != cyc || got !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d (due %0d) got gts=%b scan=%b xfer=%b flush=%b p0=%0d p1=%0d act=%b run=%b want %h got %h",
                   e.name, cyc, e.n, got[17:16], got[15:14], got[13:12], got[11:10],
                   got[9:6], got[5:2], got[1], got[0], e.exp, got);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d, bench did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //           n  rst st s0  s1  xr gts    scan   xfer   flush  p0  p1  a  r
    tbl.push_back(mk(0,  0, 1, SC, LP, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  0,  0, 0, "reset_state"));
    tbl.push_back(mk(1,  0, 0, SC, LP, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  0,  0, 1, "running"));
    tbl.push_back(mk(3,  0, 0, SC, LP, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  0,  0, 1, "prog_pre_tick"));
    tbl.push_back(mk(4,  0, 0, SC, LP, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1,  0,  0, 1, "prog_first_inc"));
    tbl.push_back(mk(20, 0, 0, SC, LP, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5,  0,  0, 1, "prog_at_5"));
    tbl.push_back(mk(21, 0, 0, SC, LP, 0, 2'b10, 2'b00, 2'b00, 2'b00, 5,  0,  0, 1, "standby_pulse"));
    tbl.push_back(mk(22, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5,  0,  0, 1, "standby_one_cycle"));
    tbl.push_back(mk(40, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 10, 0,  0, 1, "prog_full"));
    tbl.push_back(mk(44, 0, 0, ID, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 10, 0,  0, 1, "prog_saturate"));
    tbl.push_back(mk(45, 0, 0, ID, SC, 1, 2'b00, 2'b10, 2'b00, 2'b00, 10, 0,  1, 1, "scan_handoff"));
    tbl.push_back(mk(46, 0, 0, ID, SC, 1, 2'b00, 2'b00, 2'b01, 2'b00, 10, 0,  1, 1, "transfer0"));
    tbl.push_back(mk(47, 0, 0, XF, SC, 1, 2'b00, 2'b00, 2'b00, 2'b00, 10, 0,  1, 1, "transfer_once"));
    tbl.push_back(mk(48, 0, 0, XF, SC, 1, 2'b00, 2'b00, 2'b00, 2'b00, 9,  1,  1, 1, "xfer_and_scan_step"));
    tbl.push_back(mk(64, 0, 0, XF, SC, 1, 2'b00, 2'b00, 2'b00, 2'b00, 5,  5,  1, 1, "mid_pingpong"));
    tbl.push_back(mk(65, 0, 0, XF, SC, 1, 2'b00, 2'b00, 2'b00, 2'b00, 5,  5,  1, 1, "no_standby_peer_busy"));
    tbl.push_back(mk(84, 0, 0, XF, SC, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,  10, 1, 1, "xfer_empty"));
    tbl.push_back(mk(88, 0, 0, ID, SC, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  10, 1, 1, "no_wrap"));
    tbl.push_back(mk(89, 0, 0, ID, ID, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  10, 1, 1, "idle_nonactive"));
    tbl.push_back(mk(90, 0, 0, ID, ID, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0,  10, 0, 1, "overflow_flush"));
    tbl.push_back(mk(91, 0, 0, ID, ID, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,  10, 0, 1, "flush_one_cycle"));
    tbl.push_back(mk(92, 0, 0, XF, ID, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0,  10, 0, 1, "transfer_beats_flush"));
    tbl.push_back(mk(93, 1, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,  10, 0, 1, "quiet_after_xfer"));
    foreach (tbl[i]) apply(tbl[i]);

    // Flush from 5 with the peer already in standby: no standby command.
    apply(mk(94,  0, 1, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, "reset2"));
    apply(mk(95,  0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, "restart"));
    apply(mk(114, 0, 0, FL, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5, 0, 0, 1, "prog5_peer_standby"));
    apply(mk(115, 0, 0, FL, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5, 0, 0, 1, "no_standby_cmd"));
    apply(mk(118, 0, 0, FL, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3, 0, 0, 1, "flush_to_3"));
    apply(mk(122, 0, 0, FL, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, "flush_to_1"));
    apply(mk(126, 0, 0, FL, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, "flush_to_0"));
    apply(mk(130, 1, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, "flush_hold_0"));

    // Restart, extra start while running, then reset mid-scan at prog0=7.
    apply(mk(131, 0, 1, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, "reset3"));
    apply(mk(132, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, "restart2"));
    apply(mk(140, 0, 1, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2, 0, 0, 1, "before_restart_pulse"));
    apply(mk(141, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2, 0, 0, 1, "start_ignored"));
    apply(mk(142, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2, 0, 0, 1, "start_ignored2"));
    apply(mk(159, 1, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 7, 0, 0, 1, "prog_at_7"));
    apply(mk(160, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, "reset_mid_scan"));
    apply(mk(161, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, "off_after_reset"));
    apply(mk(164, 0, 0, SC, SB, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, "off_prog_tracks"));

    wait (cyc >= 166);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
